mdio_responder: RTL and testbench
=================================

MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 Parameter PHY_ADDR, default 5'd0: the PHY address this responder answers to.
REQ-002 Parameter ID1, default 16'h0022: the reset value of reg2.
REQ-003 Parameter ID2, default 16'h1622: the reset value of reg3.
REQ-004 CLK  input  1: system clock; all logic SHALL be clocked on posedge CLK.
REQ-005 RST_N  input  1: reset, asynchronous and active-low.
REQ-006 MDC  input  1: management clock from the station; asynchronous to CLK.
REQ-007 MDIO  inout  1: management data; driven only while the responder owns the bus, otherwise 1'bZ.
REQ-008 STATUS  input  16: live value returned for reg1 reads.
REQ-009 CTRL_REG  output  16: current contents of reg0.
REQ-010 WR_STB  output  1: one-CLK pulse on each committed write.
REQ-011 WR_ADDR  output  5: register address of the last committed write.
REQ-012 WR_DATA  output  16: data of the last committed write.
REQ-013 FRAME_ERR  output  1: one-CLK pulse when a frame is aborted.

Function
REQ-014 MDC and MDIO SHALL each pass through a 2-flop synchronizer; MDC rise and fall SHALL be detected from the synchronized MDC.
REQ-015 MDIO SHALL be sampled on detected MDC rise; the responder SHALL change its driven value only on detected MDC fall.
REQ-016 Correct operation SHALL be guaranteed when MDC high time and MDC low time are each at least 4 CLK periods.
REQ-017 The FSM SHALL have states IDLE, PRE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA.
REQ-018 IDLE: a 6-bit ones counter SHALL count consecutive sampled 1s, saturate at 32, and clear on any sampled 0; the FSM SHALL enter PRE when the count reaches 32.
REQ-019 PRE: sampled 1 SHALL keep PRE; sampled 0 SHALL be taken as the first ST bit and move to ST.
REQ-020 ST: sampled 1 (ST=01) SHALL go to OP; sampled 0 SHALL be an abort.
REQ-021 OP: after 2 bits, 10 SHALL mean read, 01 write, and 00/11 SHALL be an abort.
REQ-022 PHYAD and REGAD SHALL each shift in 5 bits MSB first; a PHYAD mismatch SHALL send the FSM to IDLE silently (no FRAME_ERR, never drives MDIO).
REQ-023 Read TA: the bus SHALL stay Z during TA bit 1; MDIO SHALL be driven 0 from the MDC fall after TA bit 1 is sampled.
REQ-024 RDATA: read data SHALL be latched at the end of REGAD; bits 15..0 SHALL be driven MSB first, each changing on MDC fall.
REQ-025 After the MDC fall following the rise that samples data bit 0, MDIO SHALL be released to Z and the FSM SHALL enter IDLE.
REQ-026 Write TA: sampled bits SHALL be 1 then 0; any other value SHALL be an abort with no write.
REQ-027 WDATA: 16 bits SHALL be shifted MSB first; the write SHALL commit one CLK after bit 0 is sampled, WR_STB SHALL pulse for that one CLK, and the FSM SHALL return to IDLE.
REQ-028 Register map: reg0 SHALL be R/W, reset 16'h1140.
REQ-029 Register map: reg1 SHALL be read-only and return STATUS.
REQ-030 Register map: reg2 SHALL return ID1 and reg3 SHALL return ID2; both read-only.
REQ-031 Register map: regs 4-7 SHALL be R/W, reset 0.
REQ-032 Register map: regs 8-31 SHALL read 16'h0000; writes to them SHALL be ignored.
REQ-033 Writes to read-only registers (1, 2, 3, 8-31) SHALL still pulse WR_STB with WR_ADDR/WR_DATA but SHALL NOT change storage.
REQ-034 A reg0 write with bit15=1 SHALL restore all R/W registers to reset values; bit15 SHALL read back 0 (self-clearing).
REQ-035 Abort: the FSM SHALL go to IDLE, clear the ones counter, pulse FRAME_ERR for 1 CLK, and leave MDIO Z.
REQ-036 A fresh preamble SHALL be required after every frame and after every abort.
REQ-037 A 32-ones run SHALL NOT interrupt a frame in progress; frames are never nested.

Reset
REQ-038 On RST_N low, immediately and asynchronously: MDIO SHALL be Z and the FSM SHALL enter IDLE.
REQ-039 On RST_N low: the ones counter SHALL be 0 and the synchronizers SHALL be 1.
REQ-040 On RST_N low: CTRL_REG SHALL be 16'h1140; WR_STB=0, WR_ADDR=0, WR_DATA=0, FRAME_ERR=0; regs 4-7 SHALL be 0.
REQ-041 Reset asserted mid-frame SHALL release MDIO within the same CLK; no partial write SHALL commit.

Verification
REQ-042 32x1, 01, 10, PHYAD=0, REGAD=2 -> bus Z during TA bit 1, then 0, then 16'h0022 MSB first, then Z.
REQ-043 Write reg4=16'hA5C3 -> WR_STB one pulse, WR_ADDR=4, WR_DATA=16'hA5C3; a following read of reg4 returns 16'hA5C3.
REQ-044 31 ones then frame -> ignored: no drive, no FRAME_ERR; the same frame with 32 ones -> serviced.
REQ-045 PHYAD=5'd3 with PHY_ADDR=0 -> MDIO never driven, FRAME_ERR stays 0.
REQ-046 Write with TA=11 -> FRAME_ERR pulse, no WR_STB; reg0 unchanged at 16'h1140.
REQ-047 Write reg0=16'h8000 after reg4 written -> reg4 reads 0, reg0 reads 16'h1140; RST_N pulse during RDATA -> MDIO Z the same CLK.

Source files
------------

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO management slave.
//   Oversamples MDC/MDIO on CLK, decodes preamble/ST/OP/PHYAD/REGAD/TA,
//   serves reads from a small register map and commits writes.
// Ports:
//   CLK, RST_N      system clock, async active-low reset
//   MDC             station management clock (async to CLK)
//   MDIO            bidirectional data, Z unless driving read TA/data
//   STATUS[15:0]    live value returned for reg1
//   CTRL_REG[15:0]  contents of reg0
//   WR_STB          1-CLK pulse per committed write
//   WR_ADDR/WR_DATA address/data of last committed write
//   FRAME_ERR       1-CLK pulse when a frame aborts
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter logic [15:0] ID1      = 16'h0022,
    parameter logic [15:0] ID2      = 16'h1622
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MDC,
    inout  wire         MDIO,
    input  logic [15:0] STATUS,
    output logic [15:0] CTRL_REG,
    output logic        WR_STB,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        FRAME_ERR
);

    localparam logic [15:0] CTRL_RST = 16'h1140;

    typedef enum logic [3:0] {
        IDLE, PRE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA
    } state_t;

    // ---------------- synchronizers / edge detect ----------------
    logic [1:0] mdc_sync, mdio_sync;
    logic       mdc_q;
    logic       rise, fall, din;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mdc_sync  <= 2'b11;
            mdio_sync <= 2'b11;
            mdc_q     <= 1'b1;
        end else begin
            mdc_sync  <= {mdc_sync[0], MDC};
            mdio_sync <= {mdio_sync[0], MDIO};
            mdc_q     <= mdc_sync[1];
        end
    end

    // Both inputs see the same latency, so din is aligned with rise.
    assign rise = mdc_sync[1] & ~mdc_q;
    assign fall = ~mdc_sync[1] & mdc_q;
    assign din  = mdio_sync[1];

    // ---------------- frame FSM state ----------------
    state_t      state, state_nx;
    logic [5:0]  ones_cnt, ones_nx;
    logic [3:0]  bit_cnt, bit_nx;
    logic [15:0] sh, sh_nx;          // shared shifter: OP, PHYAD, REGAD, WDATA
    logic [15:0] rd_sh, rd_sh_nx;
    logic [4:0]  reg_addr, reg_addr_nx;
    logic        is_rd, is_rd_nx;
    logic        md_oe, md_oe_nx;
    logic        md_out, md_out_nx;
    logic        rd_done, rd_done_nx;
    logic        commit, commit_nx;
    logic        abort;

    logic [3:0][15:0] rw_reg;        // regs 4..7
    logic [4:0]       ra_full;
    logic [15:0]      rd_val;

    assign MDIO = md_oe ? md_out : 1'bz;

    // Register address as it completes on the last REGAD bit.
    assign ra_full = {sh[3:0], din};

    always_comb begin
        rd_val = 16'h0000;
        case (ra_full)
            5'd0: rd_val = CTRL_REG;
            5'd1: rd_val = STATUS;
            5'd2: rd_val = ID1;
            5'd3: rd_val = ID2;
            5'd4, 5'd5, 5'd6, 5'd7: rd_val = rw_reg[ra_full[1:0]];
            default: rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ones_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
            sh       <= 16'h0000;
            rd_sh    <= 16'h0000;
            reg_addr <= 5'd0;
            is_rd    <= 1'b0;
            md_oe    <= 1'b0;
            md_out   <= 1'b0;
            rd_done  <= 1'b0;
            commit   <= 1'b0;
        end else begin
            state    <= state_nx;
            ones_cnt <= ones_nx;
            bit_cnt  <= bit_nx;
            sh       <= sh_nx;
            rd_sh    <= rd_sh_nx;
            reg_addr <= reg_addr_nx;
            is_rd    <= is_rd_nx;
            md_oe    <= md_oe_nx;
            md_out   <= md_out_nx;
            rd_done  <= rd_done_nx;
            commit   <= commit_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ones_nx     = ones_cnt;
        bit_nx      = bit_cnt;
        sh_nx       = sh;
        rd_sh_nx    = rd_sh;
        reg_addr_nx = reg_addr;
        is_rd_nx    = is_rd;
        md_oe_nx    = md_oe;
        md_out_nx   = md_out;
        rd_done_nx  = rd_done;
        commit_nx   = 1'b0;
        abort       = 1'b0;

        case (state)
            IDLE: if (rise) begin
                if (din) begin
                    if (ones_cnt != 6'd32) ones_nx = ones_cnt + 6'd1;
                    if (ones_cnt >= 6'd31) state_nx = PRE;
                end else begin
                    ones_nx = 6'd0;
                end
            end
            PRE: if (rise && !din) state_nx = ST;
            ST: if (rise) begin
                if (din) begin
                    state_nx = OP;
                    bit_nx   = 4'd0;
                end else begin
                    abort = 1'b1;
                end
            end
            OP: if (rise) begin
                sh_nx  = {sh[14:0], din};
                bit_nx = bit_cnt + 4'd1;
                if (bit_cnt == 4'd1) begin
                    bit_nx = 4'd0;
                    case ({sh[0], din})
                        2'b10:   begin is_rd_nx = 1'b1; state_nx = PHYAD; end
                        2'b01:   begin is_rd_nx = 1'b0; state_nx = PHYAD; end
                        default: abort = 1'b1;
                    endcase
                end
            end
            PHYAD: if (rise) begin
                sh_nx  = {sh[14:0], din};
                bit_nx = bit_cnt + 4'd1;
                if (bit_cnt == 4'd4) begin
                    bit_nx = 4'd0;
                    // Another PHY's frame: drop out quietly.
                    if ({sh[3:0], din} == PHY_ADDR) begin
                        state_nx = REGAD;
                    end else begin
                        state_nx = IDLE;
                        ones_nx  = 6'd0;
                    end
                end
            end
            REGAD: if (rise) begin
                sh_nx  = {sh[14:0], din};
                bit_nx = bit_cnt + 4'd1;
                if (bit_cnt == 4'd4) begin
                    bit_nx      = 4'd0;
                    reg_addr_nx = ra_full;
                    rd_sh_nx    = rd_val;
                    state_nx    = TA;
                end
            end
            TA: begin
                if (is_rd) begin
                    // Hands-off during TA bit 1, drive 0 from the following fall.
                    if (fall && bit_cnt == 4'd1) begin
                        md_oe_nx  = 1'b1;
                        md_out_nx = 1'b0;
                    end
                    if (rise) begin
                        bit_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd1) begin
                            bit_nx     = 4'd0;
                            rd_done_nx = 1'b0;
                            state_nx   = RDATA;
                        end
                    end
                end else if (rise) begin
                    bit_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd0 && !din) abort = 1'b1;
                    if (bit_cnt == 4'd1) begin
                        bit_nx = 4'd0;
                        if (din) abort = 1'b1;
                        else     state_nx = WDATA;
                    end
                end
            end
            RDATA: begin
                if (fall) begin
                    if (rd_done) begin
                        md_oe_nx   = 1'b0;
                        rd_done_nx = 1'b0;
                        ones_nx    = 6'd0;
                        state_nx   = IDLE;
                    end else begin
                        md_out_nx = rd_sh[15];
                        rd_sh_nx  = {rd_sh[14:0], 1'b0};
                    end
                end
                if (rise) begin
                    bit_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) rd_done_nx = 1'b1;
                end
            end
            WDATA: if (rise) begin
                sh_nx  = {sh[14:0], din};
                bit_nx = bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) begin
                    commit_nx = 1'b1;
                    ones_nx   = 6'd0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort) begin
            state_nx = IDLE;
            ones_nx  = 6'd0;
            md_oe_nx = 1'b0;
        end
    end

    // ---------------- register file / write commit ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CTRL_REG  <= CTRL_RST;
            rw_reg    <= '0;
            WR_STB    <= 1'b0;
            WR_ADDR   <= 5'd0;
            WR_DATA   <= 16'h0000;
            FRAME_ERR <= 1'b0;
        end else begin
            WR_STB    <= commit;
            FRAME_ERR <= abort;
            if (commit) begin
                WR_ADDR <= reg_addr;
                WR_DATA <= sh;
                if (reg_addr == 5'd0) begin
                    // bit15 is a soft reset of all R/W storage and never sticks.
                    if (sh[15]) begin
                        CTRL_REG <= CTRL_RST;
                        rw_reg   <= '0;
                    end else begin
                        CTRL_REG <= sh;
                    end
                end else if (reg_addr[4:2] == 3'b001) begin
                    rw_reg[reg_addr[1:0]] <= sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
module tb_mdio_responder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        MDC = 1'b1;
    logic [15:0] STATUS = 16'hBEEF;
    logic [15:0] CTRL_REG;
    logic        WR_STB;
    logic [4:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        FRAME_ERR;
    wire         mdio;
    logic        st_oe = 1'b0;
    logic        st_out = 1'b1;

    pullup (mdio);
    assign mdio = st_oe ? st_out : 1'bz;

    mdio_responder dut (
        .CLK(CLK), .RST_N(RST_N), .MDC(MDC), .MDIO(mdio), .STATUS(STATUS),
        .CTRL_REG(CTRL_REG), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int n_err = 0;
    int n_wr = 0;

    always @(negedge CLK) begin
        if (FRAME_ERR) n_err++;
        if (WR_STB)    n_wr++;
    end

    typedef struct {
        logic [1:0]  op;
        int          ones;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [1:0]  ta;
        logic        ta2_exp;
        logic [15:0] rd_exp;
        int          err_exp;
        int          wr_exp;
        logic [15:0] ctrl_exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t rv(int ones, logic [4:0] phy, logic [4:0] ra,
                                logic ta2, logic [15:0] d, logic [15:0] ctrl);
        vec_t v;
        v.op = 2'b10; v.ones = ones; v.phy = phy; v.ra = ra; v.wd = 16'h0;
        v.ta = 2'b00; v.ta2_exp = ta2; v.rd_exp = d; v.err_exp = 0;
        v.wr_exp = 0; v.ctrl_exp = ctrl;
        return v;
    endfunction

    function automatic vec_t wv(logic [1:0] op, int ones, logic [4:0] ra,
                                logic [15:0] wd, logic [1:0] ta, int err,
                                int wr, logic [15:0] ctrl);
        vec_t v;
        v.op = op; v.ones = ones; v.phy = 5'd0; v.ra = ra; v.wd = wd;
        v.ta = ta; v.ta2_exp = 1'b1; v.rd_exp = 16'hFFFF; v.err_exp = err;
        v.wr_exp = wr; v.ctrl_exp = ctrl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One MDC period: station sets its bit at the fall, bus sampled just before the rise.
    task automatic bit_cyc(input logic oe, input logic val, output logic smp);
        MDC = 1'b0; st_oe = oe; st_out = val;
        #50;
        smp = mdio;
        MDC = 1'b1;
        #50;
    endtask

    task automatic send_header(input int ones, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] ra);
        logic s;
        bit_cyc(1'b1, 1'b0, s);                 // zero clears any stray ones run
        for (int i = 0; i < ones; i++) bit_cyc(1'b1, 1'b1, s);
        bit_cyc(1'b1, 1'b0, s);
        bit_cyc(1'b1, 1'b1, s);
        bit_cyc(1'b1, op[1], s);
        bit_cyc(1'b1, op[0], s);
        for (int i = 4; i >= 0; i--) bit_cyc(1'b1, phy[i], s);
        for (int i = 4; i >= 0; i--) bit_cyc(1'b1, ra[i], s);
    endtask

    task automatic do_frame(input vec_t v, output logic ta1, output logic ta2,
                            output logic [15:0] rd, output logic tail);
        logic s;
        ta1 = 1'b1; ta2 = 1'b1; rd = 16'hFFFF; tail = 1'b1;
        send_header(v.ones, v.op, v.phy, v.ra);
        if (v.op == 2'b10) begin
            bit_cyc(1'b0, 1'b0, ta1);
            bit_cyc(1'b0, 1'b0, ta2);
            for (int i = 15; i >= 0; i--) begin
                bit_cyc(1'b0, 1'b0, s);
                rd[i] = s;
            end
            bit_cyc(1'b0, 1'b0, tail);
            bit_cyc(1'b0, 1'b0, s);
        end else begin
            bit_cyc(1'b1, v.ta[1], s);
            bit_cyc(1'b1, v.ta[0], s);
            for (int i = 15; i >= 0; i--) bit_cyc(1'b1, v.wd[i], s);
            bit_cyc(1'b0, 1'b0, s);
        end
    endtask

    initial begin
        logic ta1, ta2, tail, s;
        logic [15:0] rd;
        int e0, w0;
        vec_t v;

        // reset state
        #100;
        chk("rst_ctrl", 32'(CTRL_REG), 32'h1140);
        chk("rst_wr_stb", 32'(WR_STB), 32'h0);
        chk("rst_wr_addr", 32'(WR_ADDR), 32'h0);
        chk("rst_wr_data", 32'(WR_DATA), 32'h0);
        chk("rst_frame_err", 32'(FRAME_ERR), 32'h0);
        chk("rst_mdio_z", 32'(mdio), 32'h1);
        RST_N = 1'b1;
        #100;

        tbl.push_back(rv(32, 5'd0, 5'd2, 1'b0, 16'h0022, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd3, 1'b0, 16'h1622, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd1, 1'b0, 16'hBEEF, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd0, 1'b0, 16'h1140, 16'h1140));
        tbl.push_back(wv(2'b01, 32, 5'd4, 16'hA5C3, 2'b10, 0, 1, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd4, 1'b0, 16'hA5C3, 16'h1140));
        tbl.push_back(rv(31, 5'd0, 5'd2, 1'b1, 16'hFFFF, 16'h1140));  // short preamble
        tbl.push_back(rv(32, 5'd0, 5'd2, 1'b0, 16'h0022, 16'h1140));
        tbl.push_back(rv(32, 5'd3, 5'd2, 1'b1, 16'hFFFF, 16'h1140));  // other PHY
        tbl.push_back(wv(2'b01, 32, 5'd0, 16'h2100, 2'b11, 1, 0, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd0, 1'b0, 16'h1140, 16'h1140));
        tbl.push_back(wv(2'b01, 32, 5'd2, 16'h1234, 2'b10, 0, 1, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd2, 1'b0, 16'h0022, 16'h1140));
        tbl.push_back(wv(2'b01, 32, 5'd9, 16'hFFFF, 2'b10, 0, 1, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd9, 1'b0, 16'h0000, 16'h1140));
        tbl.push_back(wv(2'b11, 32, 5'd4, 16'h0000, 2'b10, 1, 0, 16'h1140)); // bad OP
        tbl.push_back(wv(2'b01, 32, 5'd7, 16'h0F0F, 2'b10, 0, 1, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd7, 1'b0, 16'h0F0F, 16'h1140));
        tbl.push_back(wv(2'b01, 36, 5'd5, 16'h5555, 2'b10, 0, 1, 16'h1140));
        tbl.push_back(rv(40, 5'd0, 5'd5, 1'b0, 16'h5555, 16'h1140));
        tbl.push_back(wv(2'b01, 32, 5'd0, 16'h0100, 2'b10, 0, 1, 16'h0100));
        tbl.push_back(rv(32, 5'd0, 5'd0, 1'b0, 16'h0100, 16'h0100));
        tbl.push_back(wv(2'b01, 32, 5'd6, 16'hFFFF, 2'b00, 1, 0, 16'h0100)); // TA=00
        tbl.push_back(rv(32, 5'd0, 5'd6, 1'b0, 16'h0000, 16'h0100));
        tbl.push_back(rv(32, 5'd0, 5'd4, 1'b0, 16'hA5C3, 16'h0100));
        tbl.push_back(wv(2'b01, 32, 5'd0, 16'h8000, 2'b10, 0, 1, 16'h1140)); // soft reset
        tbl.push_back(rv(32, 5'd0, 5'd4, 1'b0, 16'h0000, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd0, 1'b0, 16'h1140, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd7, 1'b0, 16'h0000, 16'h1140));
        tbl.push_back(rv(32, 5'd0, 5'd5, 1'b0, 16'h0000, 16'h1140));

        foreach (tbl[i]) begin
            v  = tbl[i];
            e0 = n_err;
            w0 = n_wr;
            do_frame(v, ta1, ta2, rd, tail);
            if (v.op == 2'b10) begin
                chk($sformatf("v%0d_ta1_z", i), 32'(ta1), 32'h1);
                chk($sformatf("v%0d_ta2", i), 32'(ta2), 32'(v.ta2_exp));
                chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(v.rd_exp));
                chk($sformatf("v%0d_tail_z", i), 32'(tail), 32'h1);
            end
            chk($sformatf("v%0d_frame_err", i), 32'(n_err - e0), 32'(v.err_exp));
            chk($sformatf("v%0d_wr_stb", i), 32'(n_wr - w0), 32'(v.wr_exp));
            if (v.wr_exp != 0) begin
                chk($sformatf("v%0d_wr_addr", i), 32'(WR_ADDR), 32'(v.ra));
                chk($sformatf("v%0d_wr_data", i), 32'(WR_DATA), 32'(v.wd));
            end
            chk($sformatf("v%0d_ctrl", i), 32'(CTRL_REG), 32'(v.ctrl_exp));
        end

        // Reset in the middle of RDATA while reg0 bit15 (0) is on the bus.
        send_header(32, 2'b10, 5'd0, 5'd0);
        bit_cyc(1'b0, 1'b0, s);
        bit_cyc(1'b0, 1'b0, s);
        MDC = 1'b0; st_oe = 1'b0;
        #50;
        chk("rdata_bit15_driven", 32'(mdio), 32'h0);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_read_z", 32'(mdio), 32'h1);
        #19;
        RST_N = 1'b1;
        MDC = 1'b1;
        #50;
        for (int i = 0; i < 4; i++) bit_cyc(1'b0, 1'b0, s);
        e0 = n_err;
        w0 = n_wr;
        do_frame(rv(32, 5'd0, 5'd3, 1'b0, 16'h1622, 16'h1140), ta1, ta2, rd, tail);
        chk("post_rst_read", 32'(rd), 32'h1622);
        chk("post_rst_ta2", 32'(ta2), 32'h0);

        // Reset part-way through WDATA must not commit anything.
        send_header(32, 2'b01, 5'd0, 5'd4);
        bit_cyc(1'b1, 1'b1, s);
        bit_cyc(1'b1, 1'b0, s);
        for (int i = 0; i < 15; i++) bit_cyc(1'b1, 1'b1, s);
        RST_N = 1'b0;
        #20;
        RST_N = 1'b1;
        bit_cyc(1'b1, 1'b1, s);
        bit_cyc(1'b0, 1'b0, s);
        #200;
        chk("partial_wr_no_stb", 32'(n_wr - w0), 32'h0);
        chk("partial_wr_data", 32'(WR_DATA), 32'h0);
        chk("partial_wr_no_err", 32'(n_err - e0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
